// File: rtl/rx_uart_pkg.sv
// rtl/rx_uart_pkg.sv - shared types and constants for the oversampling UART receiver
package rx_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        HOLD_CHK
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int ERR_OVR = 3;
    localparam int ERR_FRM = 2;
    localparam int ERR_PAR = 1;
    localparam int ERR_BRK = 0;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// rtl/rx_tick_gen.sv - sample tick divider, one-cycle pulse every CLK_DIV clocks, restartable
module rx_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Suppressed on restart so the first tick of a new frame is a full period away.
    assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/rx_uart_os.sv
// rtl/rx_uart_os.sv - oversampling UART receiver with one-entry holding register and RTS
// Optional: RX_MAJORITY_VOTE_EN selects 2-of-3 voting around mid-bit.
module rx_uart_os
    import rx_uart_pkg::*;
#(
    parameter int CLK_DIV     = 27,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_In,
    input  logic                 Rx_Ready,
    output logic                 Rx_Valid,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic [3:0]           Rx_Error,
    output logic                 RTS
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP_C    = CW'(OVERSAMPLE / 2);
    localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);

    rx_state_t state_q, state_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_q, frm_d;
    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic [3:0]           err_q;
    logic                 rts_q;

    logic rx_s, fall, restart, tick, sample_now, bit_val, load, brk;
    logic [3:0] err_new;

    assign rx_s    = sync_q[1];
    assign fall    = prev_q && !rx_s;
    assign restart = (state_q == IDLE) && fall;

    rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Every bit is resolved one tick after mid-bit so both sampling modes share timing.
    assign sample_now = tick && (cnt_q == SMP_C);

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] SMP_A = CW'(OVERSAMPLE / 2 - 2);
    logic [1:0] smp_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            smp_q <= 2'b11;
        end else if (tick && state_q != IDLE) begin
            if (cnt_q == SMP_A) smp_q[1] <= rx_s;
            if (cnt_q == SMP_B) smp_q[0] <= rx_s;
        end
    end

    assign bit_val = maj3(smp_q[1], smp_q[0], rx_s);
`else
    logic smp_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            smp_q <= 1'b1;
        end else if (tick && state_q != IDLE && cnt_q == SMP_B) begin
            smp_q <= rx_s;
        end
    end

    assign bit_val = smp_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pbit_d    = pbit_q;
        par_err_d = par_err_q;
        frm_d     = frm_q;
        load      = 1'b0;
        if (tick && state_q != IDLE) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    pbit_d    = 1'b0;
                    par_err_d = 1'b0;
                    frm_d     = 1'b0;
                end
            end
            START: begin
                if (sample_now) begin
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_now) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DB_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_now) begin
                    pbit_d    = bit_val;
                    par_err_d = ((^shift_q) ^ bit_val) != (PARITY_MODE == PAR_ODD);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample_now) begin
                    if (!bit_val) frm_d = 1'b1;
                    if (bit_cnt_q == SB_LAST) begin
                        state_d = HOLD_CHK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            HOLD_CHK: begin
                load    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign brk = (shift_q == '0) && frm_q && ((PARITY_MODE == PAR_NONE) || !pbit_q);

    always_comb begin
        err_new          = '0;
        err_new[ERR_OVR] = valid_q && !Rx_Ready;
        err_new[ERR_FRM] = frm_q;
        err_new[ERR_PAR] = par_err_q;
        err_new[ERR_BRK] = brk;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pbit_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
            rts_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], Rx_In};
            prev_q    <= rx_s;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pbit_q    <= pbit_d;
            par_err_q <= par_err_d;
            frm_q     <= frm_d;
            rts_q     <= !valid_q;
            // A load wins over a pop; overrun only when the old character was not taken.
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
                err_q   <= err_new;
            end else if (valid_q && Rx_Ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Rx_Valid = valid_q;
    assign Rx_Data  = data_q;
    assign Rx_Error = err_q;
    assign RTS      = rts_q;

    a_hold_stable: assert property (@(posedge Clk) disable iff (Rst)
        (Rx_Valid && !Rx_Ready && state_q != HOLD_CHK) |=> ($stable(Rx_Data) && $stable(Rx_Error)));

    a_rts: assert property (@(posedge Clk) disable iff (Rst)
        RTS == !$past(Rx_Valid));

    a_no_x: assert property (@(posedge Clk) disable iff (Rst)
        !$isunknown({Rx_Valid, Rx_Data, Rx_Error, RTS}));

endmodule

// File: tb/tb_rx_uart_os.sv
// tb/tb_rx_uart_os.sv - directed bench for rx_uart_os (8E2 and 8O1 instances)
module tb_rx_uart_os;
    import rx_uart_pkg::*;

    localparam int CD  = 4;
    localparam int OS  = 16;
    localparam int BIT = CD * OS;
    localparam int GLO = BIT / 2 - CD / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx1, rx2, rdy1, rdy2;
    logic       v1, v2, rts1, rts2;
    logic [7:0] d1, d2;
    logic [3:0] e1, e2;

    rx_uart_os #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut (
        .Clk(clk), .Rst(rst), .Rx_In(rx1), .Rx_Ready(rdy1),
        .Rx_Valid(v1), .Rx_Data(d1), .Rx_Error(e1), .RTS(rts1)
    );

    rx_uart_os #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_o (
        .Clk(clk), .Rst(rst), .Rx_In(rx2), .Rx_Ready(rdy2),
        .Rx_Valid(v2), .Rx_Data(d2), .Rx_Error(e2), .RTS(rts2)
    );

    int passed = 0;
    int total  = 0;
    int pops1 = 0, pops2 = 0, vcyc1 = 0;
    logic [7:0] last_d1 = '0, last_d2 = '0;
    logic [3:0] last_e1 = '0, last_e2 = '0;
    logic watch_rts = 1'b0;
    logic rts_high_seen = 1'b0;

    always @(negedge clk) begin
        if (v1) vcyc1++;
        if (v1 && rdy1) begin pops1++; last_d1 = d1; last_e1 = e1; end
        if (v2 && rdy2) begin pops2++; last_d2 = d2; last_e2 = e2; end
        if (watch_rts && rts1) rts_high_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int sel, input logic [15:0] bits, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BIT; c++) begin
                logic b;
                b = bits[i];
                if (i == gbit && c >= GLO && c < GLO + CD) b = ~b;
                if (sel == 1) rx1 = b; else rx2 = b;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (v1 !== 1'b0)   $display("FAIL rst_valid: got %b expected 0", v1);   else passed++;
        total++; if (d1 !== 8'h00)  $display("FAIL rst_data: got %h expected 00", d1);  else passed++;
        total++; if (e1 !== 4'h0)   $display("FAIL rst_err: got %b expected 0000", e1); else passed++;
        total++; if (rts1 !== 1'b1) $display("FAIL rst_rts: got %b expected 1", rts1);  else passed++;
        total++; if (v2 !== 1'b0 || rts2 !== 1'b1)
            $display("FAIL rst_dut_o: got valid=%b rts=%b expected valid=0 rts=1", v2, rts2); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_8e2;
        int p0, c0;
        p0 = pops1; c0 = vcyc1;
        send_frame(1, {2'b11, 1'b0, 8'h55, 1'b0}, 12, -1);
        idle(BIT);
        total++; if (pops1 - p0 !== 1) $display("FAIL 8e2_count: got %0d expected 1", pops1 - p0); else passed++;
        total++; if (vcyc1 - c0 !== 1) $display("FAIL 8e2_valid_cycles: got %0d expected 1", vcyc1 - c0); else passed++;
        total++; if (last_d1 !== 8'h55) $display("FAIL 8e2_data: got %h expected 55", last_d1); else passed++;
        total++; if (last_e1 !== 4'b0000) $display("FAIL 8e2_err: got %b expected 0000", last_e1); else passed++;
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pops1;
        send_frame(1, {2'b11, 1'b0, 8'h55, 1'b0}, 12, -1);
        send_frame(1, {2'b11, 1'b0, 8'h0F, 1'b0}, 12, -1);
        idle(BIT);
        total++; if (pops1 - p0 !== 2) $display("FAIL b2b_count: got %0d expected 2", pops1 - p0); else passed++;
        total++; if (last_d1 !== 8'h0F) $display("FAIL b2b_data: got %h expected 0f", last_d1); else passed++;
        total++; if (last_e1 !== 4'b0000) $display("FAIL b2b_err: got %b expected 0000", last_e1); else passed++;
    endtask

    task automatic test_parity_err;
        int p0;
        p0 = pops2;
        send_frame(2, {1'b1, 1'b0, 8'hA3, 1'b0}, 11, -1);
        idle(BIT);
        total++; if (pops2 - p0 !== 1) $display("FAIL par_count: got %0d expected 1", pops2 - p0); else passed++;
        total++; if (last_d2 !== 8'hA3) $display("FAIL par_data: got %h expected a3", last_d2); else passed++;
        total++; if (last_e2 !== 4'b0010) $display("FAIL par_err: got %b expected 0010", last_e2); else passed++;
    endtask

    task automatic test_break;
        int p0;
        p0 = pops1;
        rx1 = 1'b0;
        idle(24 * BIT);
        rx1 = 1'b1;
        idle(2 * BIT);
        total++; if (pops1 - p0 !== 1) $display("FAIL brk_count: got %0d expected 1", pops1 - p0); else passed++;
        total++; if (last_d1 !== 8'h00) $display("FAIL brk_data: got %h expected 00", last_d1); else passed++;
        total++; if (last_e1 !== 4'b0101) $display("FAIL brk_err: got %b expected 0101", last_e1); else passed++;
    endtask

    task automatic test_overrun;
        rdy1 = 1'b0;
        send_frame(1, {2'b11, 1'b0, 8'h11, 1'b0}, 12, -1);
        @(negedge clk);
        total++; if (v1 !== 1'b1 || rts1 !== 1'b0)
            $display("FAIL ovr_first: got valid=%b rts=%b expected valid=1 rts=0", v1, rts1); else passed++;
        total++; if (d1 !== 8'h11) $display("FAIL ovr_first_data: got %h expected 11", d1); else passed++;
        @(posedge clk); #1;
        rts_high_seen = 1'b0;
        watch_rts = 1'b1;
        send_frame(1, {2'b11, 1'b0, 8'h22, 1'b0}, 12, -1);
        watch_rts = 1'b0;
        @(negedge clk);
        total++; if (d1 !== 8'h22) $display("FAIL ovr_data: got %h expected 22", d1); else passed++;
        total++; if (e1 !== 4'b1000) $display("FAIL ovr_err: got %b expected 1000", e1); else passed++;
        total++; if (rts_high_seen !== 1'b0) $display("FAIL ovr_rts_low: got rts high seen=%b expected 0", rts_high_seen); else passed++;
        @(posedge clk); #1;
        rdy1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (v1 !== 1'b0 || rts1 !== 1'b0)
            $display("FAIL ovr_pop: got valid=%b rts=%b expected valid=0 rts=0", v1, rts1); else passed++;
        @(negedge clk);
        total++; if (rts1 !== 1'b1) $display("FAIL ovr_rts_rise: got %b expected 1", rts1); else passed++;
        @(posedge clk); #1;
        idle(BIT);
    endtask

    task automatic test_glitch;
        int p0, c0;
        p0 = pops1; c0 = vcyc1;
        rx1 = 1'b0;
        idle(OS / 4 * CD);
        rx1 = 1'b1;
        idle(14 * BIT);
        total++; if (vcyc1 - c0 !== 0 || pops1 - p0 !== 0)
            $display("FAIL glitch_valid: got %0d valid cycles expected 0", vcyc1 - c0); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL glitch_idle: got state %0d expected %0d", dut.state_q, IDLE); else passed++;
    endtask

    task automatic test_reset_mid;
        int p0, g;
        send_frame(1, {2'b11, 1'b0, 8'h33, 1'b0}, 4, -1);
        rst = 1'b1;
        @(negedge clk);
        total++; if (dut.state_q !== IDLE || v1 !== 1'b0)
            $display("FAIL rstmid_idle: got state=%0d valid=%b expected state=%0d valid=0", dut.state_q, v1, IDLE); else passed++;
        rx1 = 1'b1;
        @(posedge clk); #1;
        idle(2);
        rst = 1'b0;
        idle(BIT);
        p0 = pops1;
`ifdef RX_MAJORITY_VOTE_EN
        g = 2;
`else
        g = -1;
`endif
        send_frame(1, {2'b11, 1'b0, 8'h7E, 1'b0}, 12, g);
        idle(BIT);
        total++; if (pops1 - p0 !== 1) $display("FAIL rstmid_count: got %0d expected 1", pops1 - p0); else passed++;
        total++; if (last_d1 !== 8'h7E) $display("FAIL rstmid_data: got %h expected 7e", last_d1); else passed++;
        total++; if (last_e1 !== 4'b0000) $display("FAIL rstmid_err: got %b expected 0000", last_e1); else passed++;
    endtask

    initial begin
        rst = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_8e2();
        test_back_to_back();
        test_parity_err();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rx_uart_os.md
# rx_uart_os

Parametrised, oversampling UART receiver; successor to the fixed-format receive FSM. Samples the asynchronous serial line at OVERSAMPLE× the bit rate and rejects false starts. Supports 5–9 data bits, none/even/odd parity and 1–2 stop bits. Delivers each character with its error flags through a one-entry valid/ready holding register to the host-side logic, and drives RTS for flow control.

## Interface
- CLK_DIV, 27 — Clk cycles per sample tick (≥1); bit rate = f_Clk / (CLK_DIV·OVERSAMPLE)
- OVERSAMPLE, 16 — sample ticks per bit; even, ≥4
- DATA_BITS, 8 — data bits per character, 5..9
- PARITY_MODE, 1 — 0 none, 1 even, 2 odd
- STOP_BITS, 2 — 1 or 2
- Clk  input  1  system clock
- Rst  input  1  reset, asynchronous, active-high
- Rx_In  input  1  serial line, asynchronous, idle high
- Rx_Ready  input  1  consumer accepts character when high with Rx_Valid
- Rx_Valid  output  1  holding register contains a character
- Rx_Data  output  DATA_BITS  received character, LSB = first bit on the line
- Rx_Error  output  4  {overrun, framing, parity, break}, qualified by Rx_Valid
- RTS  output  1  high = sender may transmit; low while holding register full

## Operation
- Rx_In passes through a 2-flop synchroniser, reset to 1; all FSM logic uses the synchronised value.
- The tick generator pulses one Clk every CLK_DIV cycles. It is free-running but restarts when IDLE sees a falling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, HOLD_CHK.
- IDLE: a synchronised falling edge → START, sample counter = 0.
- START: at tick OVERSAMPLE/2 the line is resampled. If it is high → IDLE (glitch, nothing reported). If it is low → DATA.
- DATA: the line is sampled every OVERSAMPLE ticks at mid-bit and shifted in LSB-first. After DATA_BITS samples → PARITY, or → STOP when PARITY_MODE=0.
- PARITY: one mid-bit sample. The parity error flag is set if the XOR of the data and parity bits ≠ (PARITY_MODE==2).
- STOP: STOP_BITS mid-bit samples. Any low sample sets the framing error flag. After the last sample → HOLD_CHK.
- HOLD_CHK: break = data all zero AND framing error AND parity bit (if present) zero. The character and flags load into the holding register. Overrun is set if the holding register was still full, in which case the new character overwrites it. Then → IDLE.
- Handshake: Rx_Valid && Rx_Ready empties the register in that cycle. A load and a pop in the same cycle count as a load with no overrun.
- RTS = !Rx_Valid, registered.
- Mid-frame Rst returns to IDLE immediately. The partial character is discarded.

## Timing
- Reset values: Rx_Valid 0, Rx_Data 0, Rx_Error 0, RTS 1, state IDLE.
- Start-edge detection lags Rx_In by 2 Clk (synchroniser).
- Rx_Valid rises on the 2nd Clk after the tick that samples the final stop bit. Flags are stable while Rx_Valid is high.
- RTS falls on the Clk after Rx_Valid rises. It rises on the Clk after the pop.
- The receiver returns to IDLE mid-way through the last stop bit, so back-to-back frames with no idle gap are received.

## Configuration
- RX_MAJORITY_VOTE_EN defined: every bit sample is the 2-of-3 majority of ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. This applies to the start-bit check as well.
- RX_MAJORITY_VOTE_EN undefined: a single sample at tick OVERSAMPLE/2. Bit timing is identical in both cases.

## Structure
- Package rx_uart_pkg holds:
  - the state enum rx_state_t
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - error bit index constants ERR_OVR, ERR_FRM, ERR_PAR, ERR_BRK
- Sub-module rx_tick_gen contains the CLK_DIV counter and tick output with a restart input.
- Concurrent assertions cover:
  - Rx_Data/Rx_Error are stable while Rx_Valid && !Rx_Ready
  - RTS == !$past(Rx_Valid)
  - no X on any output after reset

## Test plan
- 8E2, 0x55 with correct parity, Rx_Ready=1 → Rx_Valid one cycle, Rx_Data=0x55, Rx_Error=0.
- 8O1, 0xA3 with a wrong parity bit → Rx_Data=0xA3, Rx_Error=4'b0010.
- Line held low for 2 character times → Rx_Data=0x00, Rx_Error=4'b0101 (break+framing).
- Rx_Ready=0, two frames 0x11 then 0x22 → after the second, Rx_Data=0x22, overrun=1, RTS=0 throughout.
- Low pulse of OVERSAMPLE/4 ticks on an idle line → no Rx_Valid, FSM back in IDLE.
- Rst asserted mid-DATA, then a clean 0x7E frame → only 0x7E delivered with no errors. With the macro defined, a single-tick glitch at mid-bit does not corrupt 0x7E.
